// File: rtl/image_rotate_scanner.sv
// Purpose: raster-scans the destination frame, asks the rotation engine where each pixel comes from, then copies the source pixel or fills background.
// Latency: per pixel 1 REQ + L WAIT + 1 READ (in range only) + 1 WRITE; one DONE cycle closes the frame.
// Backpressure: stalls in WAIT until i_rot_done; both RAMs have a fixed one-cycle latency, so writes are never held off.
module image_rotate_scanner #(
   parameter int                     IMAGE_SIZE     = 60,
   parameter int                     IMAGE_COOR_BIT = 6,
   parameter int                     ANG_WIDTH      = 9,
   parameter int                     PIXEL_WIDTH    = 8,
   parameter int                     ADDR_WIDTH     = 12,
   parameter logic [PIXEL_WIDTH-1:0] BG_PIXEL       = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [ANG_WIDTH-1:0]      i_angle,
   output logic                      o_rot_start,
   output logic [IMAGE_COOR_BIT-1:0] o_rot_H,
   output logic [IMAGE_COOR_BIT-1:0] o_rot_V,
   output logic [ANG_WIDTH-1:0]      o_rot_angle,
   input  logic [IMAGE_COOR_BIT-1:0] i_rot_H,
   input  logic [IMAGE_COOR_BIT-1:0] i_rot_V,
   input  logic                      i_rot_outOfRange,
   input  logic                      i_rot_done,
   output logic                      o_src_rd,
   output logic [ADDR_WIDTH-1:0]     o_src_addr,
   input  logic [PIXEL_WIDTH-1:0]    i_src_data,
   output logic                      o_dst_we,
   output logic [ADDR_WIDTH-1:0]     o_dst_addr,
   output logic [PIXEL_WIDTH-1:0]    o_dst_data,
   output logic                      o_busy,
   output logic                      o_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [IMAGE_COOR_BIT-1:0] COOR_LAST = IMAGE_COOR_BIT'(IMAGE_SIZE - 1);
   localparam logic [IMAGE_COOR_BIT-1:0] COOR_ONE  = IMAGE_COOR_BIT'(1);
   localparam logic [IMAGE_COOR_BIT-1:0] COOR_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0]     SIZE_A    = ADDR_WIDTH'(IMAGE_SIZE);
   localparam logic [ANG_WIDTH-1:0]      ANG_ZERO  = '0;

   logic [2:0]                state;
   logic [2:0]                state_nxt;
   logic [IMAGE_COOR_BIT-1:0] h_r;
   logic [IMAGE_COOR_BIT-1:0] v_r;
   logic [IMAGE_COOR_BIT-1:0] rot_h_r;
   logic [IMAGE_COOR_BIT-1:0] rot_v_r;
   logic [ANG_WIDTH-1:0]      angle_r;
   logic                      oor_r;

   // The engine flag is trusted, but a coordinate past the frame edge is also
   // treated as background so a misbehaving engine can never address outside the RAM.
   logic rot_oor;
   logic last_h;
   logic last_pix;

   assign rot_oor  = i_rot_outOfRange | (i_rot_H > COOR_LAST) | (i_rot_V > COOR_LAST);
   assign last_h   = (h_r == COOR_LAST);
   assign last_pix = last_h & (v_r == COOR_LAST);

   // Next-state decode; i_rot_done only matters while waiting on the engine.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT:  if (i_rot_done) state_nxt = rot_oor ? S_WRITE : S_READ;
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = last_pix ? S_DONE : S_REQ;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Frame datapath: angle latch, raster counters and captured engine result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_r     <= '0;
         v_r     <= '0;
         rot_h_r <= '0;
         rot_v_r <= '0;
         angle_r <= '0;
         oor_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  angle_r <= i_angle;
                  h_r     <= '0;
                  v_r     <= '0;
               end
            end
            S_WAIT: begin
               if (i_rot_done) begin
                  rot_h_r <= i_rot_H;
                  rot_v_r <= i_rot_V;
                  oor_r   <= rot_oor;
               end
            end
            S_WRITE: begin
               if (!last_pix) begin
                  if (last_h) begin
                     h_r <= COOR_ZERO;
                     v_r <= v_r + COOR_ONE;
                  end else begin
                     h_r <= h_r + COOR_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // All outputs are decodes of registered state; data is forced to zero outside
   // WRITE so nothing leaks from the source bus while idle or in reset.
   assign o_rot_start = (state == S_REQ);
   assign o_rot_H     = h_r;
   assign o_rot_V     = v_r;
   assign o_rot_angle = ANG_ZERO - angle_r;
   assign o_src_rd    = (state == S_READ);
   assign o_src_addr  = ADDR_WIDTH'(rot_v_r) * SIZE_A + ADDR_WIDTH'(rot_h_r);
   assign o_dst_we    = (state == S_WRITE);
   assign o_dst_addr  = ADDR_WIDTH'(v_r) * SIZE_A + ADDR_WIDTH'(h_r);
   assign o_dst_data  = (state != S_WRITE) ? '0 : (oor_r ? BG_PIXEL : i_src_data);
   assign o_busy      = (state != S_IDLE);
   assign o_done      = (state == S_DONE);

endmodule

// File: tb/tb_image_rotate_scanner.sv
// Purpose: directed frames against behavioural engine / source RAM models, checking frame totals and destination contents.
// Latency: engine answers L cycles into WAIT (L set per frame); source RAM answers one cycle after the read strobe.
// Backpressure: engine latency and a done held high across REQ are the only stall sources exercised.
module tb_image_rotate_scanner;

   localparam int N = 60;

   logic       i_clk   = 1'b0;
   logic       i_rst_n = 1'b1;
   logic       i_start = 1'b0;
   logic [8:0] i_angle = '0;
   logic       o_rot_start;
   logic [5:0] o_rot_H;
   logic [5:0] o_rot_V;
   logic [8:0] o_rot_angle;
   logic [5:0] i_rot_H = '0;
   logic [5:0] i_rot_V = '0;
   logic       i_rot_outOfRange = 1'b0;
   logic       i_rot_done;
   logic       o_src_rd;
   logic [11:0] o_src_addr;
   logic [7:0] i_src_data = '0;
   logic       o_dst_we;
   logic [11:0] o_dst_addr;
   logic [7:0] o_dst_data;
   logic       o_busy;
   logic       o_done;

   image_rotate_scanner dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_start          (i_start),
      .i_angle          (i_angle),
      .o_rot_start      (o_rot_start),
      .o_rot_H          (o_rot_H),
      .o_rot_V          (o_rot_V),
      .o_rot_angle      (o_rot_angle),
      .i_rot_H          (i_rot_H),
      .i_rot_V          (i_rot_V),
      .i_rot_outOfRange (i_rot_outOfRange),
      .i_rot_done       (i_rot_done),
      .o_src_rd         (o_src_rd),
      .o_src_addr       (o_src_addr),
      .i_src_data       (i_src_data),
      .o_dst_we         (o_dst_we),
      .o_dst_addr       (o_dst_addr),
      .o_dst_data       (o_dst_data),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   always #5 i_clk = ~i_clk;

   int vec  = 0;
   int miss = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Engine model. mode 0 identity, 1 rotation by 90 about (30,30), 2 always out of range,
   // 3 identity except pixel (5,0) which returns H=60 with the flag clear.
   int   mode  = 0;
   int   lat   = 1;
   bit   stuck = 1'b0;
   int   rem   = 0;
   logic done_m = 1'b0;
   assign i_rot_done = done_m | stuck;

   // Engine answers on falling edges: request seen in REQ, done raised in the L-th WAIT cycle.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         rem    = 0;
         done_m = 1'b0;
      end else if (o_rot_start) begin
         int h;
         int v;
         h      = int'(o_rot_H);
         v      = int'(o_rot_V);
         rem    = lat;
         done_m = 1'b0;
         i_rot_H = o_rot_H;
         i_rot_V = o_rot_V;
         i_rot_outOfRange = 1'b0;
         case (mode)
            1: begin
               i_rot_H = o_rot_V;
               if (h == 0) begin
                  i_rot_V = 6'd0;
                  i_rot_outOfRange = 1'b1;
               end else begin
                  i_rot_V = 6'(N - h);
               end
            end
            2: i_rot_outOfRange = 1'b1;
            3: if (h == 5 && v == 0) i_rot_H = 6'd60;
            default: ;
         endcase
      end else if (rem > 0) begin
         rem--;
         done_m = (rem == 0);
      end else begin
         done_m = 1'b0;
      end
   end

   // Source RAM: src[a] = a mod 256, valid the cycle after the read; junk otherwise.
   always @(negedge i_clk) begin
      if (o_src_rd)       i_src_data = o_src_addr[7:0];
      else if (!o_dst_we) i_src_data = 8'hEE;
   end

   // Output monitor.
   logic [7:0] dst [0:4095];
   int   busy_cnt, done_cnt, done_at, start_cnt, wr_cnt, rd_cnt, order_bad, ang_bad, first_addr;
   logic [8:0] exp_ang;

   always @(negedge i_clk) begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
         done_cnt++;
         done_at = busy_cnt;
      end
      if (o_rot_start) begin
         start_cnt++;
         if (o_rot_angle !== exp_ang) ang_bad++;
      end
      if (o_src_rd) rd_cnt++;
      if (o_dst_we) begin
         if (wr_cnt == 0) first_addr = int'(o_dst_addr);
         if (int'(o_dst_addr) != wr_cnt) order_bad++;
         dst[o_dst_addr] = o_dst_data;
         wr_cnt++;
      end
   end

   function automatic logic [7:0] exp_pix(input int m, input int a);
      int h;
      int v;
      logic [11:0] sa;
      h = a % N;
      v = a / N;
      case (m)
         1: begin
            if (h == 0) return 8'h00;
            sa = 12'((N - h) * N + v);
            return sa[7:0];
         end
         2: return 8'h00;
         3: begin
            if (a == 5) return 8'h00;
            sa = 12'(a);
            return sa[7:0];
         end
         default: begin
            sa = 12'(a);
            return sa[7:0];
         end
      endcase
   endfunction

   task automatic start_frame(input logic [8:0] ang, input logic [8:0] neg_ang);
      @(posedge i_clk);
      #1;
      busy_cnt = 0; done_cnt = 0; done_at = 0; start_cnt = 0; wr_cnt = 0;
      rd_cnt = 0; order_bad = 0; ang_bad = 0; first_addr = -1;
      exp_ang = neg_ang;
      for (int a = 0; a < 4096; a++) dst[a] = 8'hxx;
      i_angle = ang;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_angle = 9'h0AA;
   endtask

   task automatic wait_frame(input int budget);
      int i;
      i = 0;
      while (done_cnt == 0 && i < budget) begin
         @(negedge i_clk);
         #1;
         i++;
      end
      repeat (4) @(negedge i_clk);
      #1;
      check("frame_done_once", 64'(done_cnt), 64'd1);
   endtask

   task automatic check_dst(input string tag, input int m);
      int bad;
      bad = 0;
      for (int a = 0; a < N * N; a++)
         if (dst[a] !== exp_pix(m, a)) bad++;
      check(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      // Reset state
      #1 i_rst_n = 1'b0;
      #11;
      check("rst_ctrl", {o_rot_start, o_src_rd, o_dst_we, o_busy, o_done}, 64'd0);
      check("rst_data", {o_rot_H, o_rot_V, o_rot_angle, o_src_addr, o_dst_addr, o_dst_data}, 64'd0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      // Frame 1: identity engine, angle 0, L = 1
      mode = 0; lat = 1;
      start_frame(9'd0, 9'h000);
      wait_frame(20000);
      check("id_busy_cycles", 64'(busy_cnt), 64'd14401);
      check("id_done_at", 64'(done_at), 64'd14401);
      check("id_rot_starts", 64'(start_cnt), 64'd3600);
      check("id_writes", 64'(wr_cnt), 64'd3600);
      check("id_order", 64'(order_bad), 64'd0);
      check("id_src_reads", 64'(rd_cnt), 64'd3600);
      check("id_angle", 64'(ang_bad), 64'd0);
      check_dst("id_dst", 0);

      // Frame 2: rotation by 90, with a restart attempt and angle change mid-frame
      mode = 1; lat = 1;
      start_frame(9'd90, 9'h1A6);
      repeat (2000) @(negedge i_clk);
      i_angle = 9'd30;
      i_start = 1'b1;
      repeat (3) @(negedge i_clk);
      i_start = 1'b0;
      wait_frame(20000);
      check("r90_busy_cycles", 64'(busy_cnt), 64'd14341);
      check("r90_rot_starts", 64'(start_cnt), 64'd3600);
      check("r90_angle", 64'(ang_bad), 64'd0);
      check("r90_src_reads", 64'(rd_cnt), 64'd3540);
      check("r90_order", 64'(order_bad), 64'd0);
      check("r90_dst0", 64'(dst[0]), 64'h00);
      check("r90_dst1", 64'(dst[1]), 64'd212);
      check("r90_dst119", 64'(dst[119]), 64'd61);
      check_dst("r90_dst", 1);

      // Frame 3: engine always out of range, L = 3, angle -180
      mode = 2; lat = 3;
      start_frame(9'h14C, 9'h0B4);
      wait_frame(25000);
      check("oor_busy_cycles", 64'(busy_cnt), 64'd18001);
      check("oor_src_reads", 64'(rd_cnt), 64'd0);
      check("oor_writes", 64'(wr_cnt), 64'd3600);
      check("oor_angle", 64'(ang_bad), 64'd0);
      check_dst("oor_dst", 2);

      // Frame 4: done held high through REQ; pixel (5,0) returns H = 60 unflagged
      mode = 3; lat = 1; stuck = 1'b1;
      start_frame(9'd180, 9'h14C);
      wait_frame(20000);
      stuck = 1'b0;
      check("edge_busy_cycles", 64'(busy_cnt), 64'd14400);
      check("edge_src_reads", 64'(rd_cnt), 64'd3599);
      check("edge_dst5", 64'(dst[5]), 64'h00);
      check("edge_angle", 64'(ang_bad), 64'd0);
      check_dst("edge_dst", 3);

      // Frame 5: reset after 100 writes, then a clean restart
      mode = 0; lat = 1;
      start_frame(9'd45, 9'h1D3);
      for (int i = 0; i < 1000 && wr_cnt < 100; i++) begin
         @(negedge i_clk);
         #1;
      end
      check("pre_rst_writes", 64'(wr_cnt), 64'd100);
      check("pre_rst_angle", 64'(o_rot_angle), 64'h1D3);
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("arst_ctrl", {o_rot_start, o_src_rd, o_dst_we, o_busy, o_done}, 64'd0);
      check("arst_data", {o_rot_H, o_rot_V, o_rot_angle, o_src_addr, o_dst_addr, o_dst_data}, 64'd0);
      repeat (5) @(negedge i_clk);
      check("arst_no_done", 64'(done_cnt), 64'd0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      start_frame(9'd0, 9'h000);
      for (int i = 0; i < 50 && wr_cnt < 2; i++) begin
         @(negedge i_clk);
         #1;
      end
      check("restart_first_addr", 64'(first_addr), 64'd0);
      check("restart_order", 64'(order_bad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
